// File: rtl/mul8_mac_pkg.sv
// Shared types and helpers for the mul8 multiply-accumulate stage.
package mul8_mac_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } mac_state_e;

    localparam int unsigned PROD_W    = 8;
    localparam int unsigned ACC_W_MAX = 32;

    // Widened to the largest legal accumulator; callers cast down to their ACC_W.
    function automatic logic [ACC_W_MAX-1:0] zext_prod(input logic [PROD_W-1:0] prod);
        return {{(ACC_W_MAX - PROD_W){1'b0}}, prod};
    endfunction

endpackage

// File: rtl/mul8_lo.sv
// Combinational 8x8 multiplier returning only the low 8 bits of the product.
module mul8_lo
    import mul8_mac_pkg::*;
(
    input  logic [PROD_W-1:0] a_i,
    input  logic [PROD_W-1:0] b_i,
    output logic [PROD_W-1:0] p_o
);

    // Shift-and-add; carries past bit 7 fall off, giving the product modulo 256.
    always_comb begin
        p_o = '0;
        for (int i = 0; i < PROD_W; i++) begin
            if (b_i[i]) begin
                p_o = p_o + (a_i << i);
            end
        end
    end

endmodule

// File: rtl/mul8_mac_stage.sv
// Multiply-accumulate stage: sums low products per frame and presents sum, count and
// sticky overflow under a valid/ready handshake.
module mul8_mac_stage
    import mul8_mac_pkg::*;
#(
    parameter int unsigned ACC_W     = 16,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MAX_BEATS = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] MaxBeats = CNT_W'(MAX_BEATS);

    mac_state_e state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_ovf_q, out_ovf_d;

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]    add_full;
    logic [CNT_W-1:0]  cnt_inc;
    logic              beat;

    mul8_lo u_mul8_lo (
        .a_i (in_a),
        .b_i (in_b),
        .p_o (prod)
    );

    assign prod_ext = ACC_W'(zext_prod(prod));
    // One extra bit keeps the carry-out for the sticky overflow flag.
    assign add_full = {1'b0, acc_q} + {1'b0, prod_ext};
    assign cnt_inc  = cnt_q + 1'b1;

    // Ready and valid come straight from the state register, so no path from out_ready.
    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign beat      = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        sum_d     = sum_q;
        count_d   = count_q;
        out_ovf_d = out_ovf_q;

        unique case (state_q)
            IDLE, ACC: begin
                if (beat) begin
                    acc_d = add_full[ACC_W-1:0];
                    ovf_d = ovf_q | add_full[ACC_W];
                    cnt_d = cnt_inc;
                    if (in_last || (cnt_inc == MaxBeats)) begin
                        state_d   = HOLD;
                        sum_d     = add_full[ACC_W-1:0];
                        count_d   = cnt_inc;
                        out_ovf_d = ovf_q | add_full[ACC_W];
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            sum_q     <= sum_d;
            count_q   <= count_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign out_sum   = sum_q;
    assign out_count = count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mul8_mac_stage.sv
// Self-checking bench for mul8_mac_stage: three configurations against a frame-level model.
module tb_mul8_mac_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] in_valid;
    logic [7:0] in_a, in_b;
    logic       in_last;
    logic       out_ready;

    wire        rdy0, rdy1, rdy2;
    wire        vld0, vld1, vld2;
    wire        ovf0, ovf1, ovf2;
    wire [15:0] sum0, sum2;
    wire [9:0]  sum1;
    wire [7:0]  cnt0, cnt1, cnt2;

    // dut0: defaults, dut1: narrow accumulator, dut2: forced end after 4 beats.
    mul8_mac_stage #(.ACC_W(16), .CNT_W(8), .MAX_BEATS(255)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(rdy0), .in_a(in_a),
        .in_b(in_b), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
        .out_sum(sum0), .out_count(cnt0), .out_ovf(ovf0)
    );
    mul8_mac_stage #(.ACC_W(10), .CNT_W(8), .MAX_BEATS(255)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(rdy1), .in_a(in_a),
        .in_b(in_b), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
        .out_sum(sum1), .out_count(cnt1), .out_ovf(ovf1)
    );
    mul8_mac_stage #(.ACC_W(16), .CNT_W(8), .MAX_BEATS(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(rdy2), .in_a(in_a),
        .in_b(in_b), .in_last(in_last), .out_valid(vld2), .out_ready(out_ready),
        .out_sum(sum2), .out_count(cnt2), .out_ovf(ovf2)
    );

    int          sel;
    logic [31:0] o_sum;
    logic [7:0]  o_cnt;
    logic        o_valid, o_ready, o_ovf;

    always_comb begin
        o_sum   = 32'(sum0);
        o_cnt   = cnt0;
        o_valid = vld0;
        o_ready = rdy0;
        o_ovf   = ovf0;
        if (sel == 1) begin
            o_sum   = 32'(sum1);
            o_cnt   = cnt1;
            o_valid = vld1;
            o_ready = rdy1;
            o_ovf   = ovf1;
        end else if (sel == 2) begin
            o_sum   = 32'(sum2);
            o_cnt   = cnt2;
            o_valid = vld2;
            o_ready = rdy2;
            o_ovf   = ovf2;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level reference: running total of products; the result wraps modulo 2^ACC_W
    // and overflow is simply "the true total reached 2^ACC_W".
    longint      m_total [3];
    int          m_cnt   [3];
    logic [31:0] e_sum;
    int          e_cnt;
    logic        e_ovf;

    function automatic int acc_w_of(input int k);
        return (k == 1) ? 10 : 16;
    endfunction

    function automatic int max_of(input int k);
        return (k == 2) ? 4 : 255;
    endfunction

    function automatic bit model_accept(input int k, input logic [7:0] a, input logic [7:0] b,
                                        input logic last);
        longint lim;
        lim = longint'(1) << acc_w_of(k);
        m_total[k] += longint'((int'(a) * int'(b)) % 256);
        m_cnt[k]++;
        if (last || m_cnt[k] == max_of(k)) begin
            e_sum = 32'(m_total[k] % lim);
            e_ovf = (m_total[k] >= lim);
            e_cnt = m_cnt[k];
            m_total[k] = 0;
            m_cnt[k] = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic send_beat(input int k, input logic [7:0] a, input logic [7:0] b,
                             input logic last, output bit ended);
        int waited;
        sel = k;
        in_a = a;
        in_b = b;
        in_last = last;
        in_valid[k] = 1'b1;
        ended = 1'b0;
        waited = 0;
        @(negedge clk);
        while (!o_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!o_ready) begin
            check_eq("beat_accept_timeout", 32'(o_ready), 1);
            in_valid[k] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_last = 1'b0;
        ended = model_accept(k, a, b, last);
        if (ended) begin
            @(negedge clk);
            check_eq("result_valid", 32'(o_valid), 1);
            check_eq("result_sum", o_sum, e_sum);
            check_eq("result_count", 32'(o_cnt), 32'(e_cnt));
            check_eq("result_ovf", 32'(o_ovf), 32'(e_ovf));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_frame(input string tag, input int sum, input int cnt, input int ovf);
        @(negedge clk);
        check_eq({tag, "_valid"}, 32'(o_valid), 1);
        check_eq({tag, "_sum"}, o_sum, 32'(sum));
        check_eq({tag, "_count"}, 32'(o_cnt), 32'(cnt));
        check_eq({tag, "_ovf"}, 32'(o_ovf), 32'(ovf));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int hold);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_valid", 32'(o_valid), 1);
            check_eq("hold_sum", o_sum, e_sum);
            check_eq("hold_count", 32'(o_cnt), 32'(e_cnt));
            check_eq("hold_in_ready", 32'(o_ready), 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("fire_valid_low", 32'(o_valid), 0);
        check_eq("fire_in_ready", 32'(o_ready), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            m_total[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic check_reset(input int k);
        sel = k;
        @(negedge clk);
        check_eq("rst_valid", 32'(o_valid), 0);
        check_eq("rst_sum", o_sum, 0);
        check_eq("rst_count", 32'(o_cnt), 0);
        check_eq("rst_ovf", 32'(o_ovf), 0);
        check_eq("rst_in_ready", 32'(o_ready), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ended;
        rst_n = 1'b0;
        in_valid = '0;
        in_a = '0;
        in_b = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        sel = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        for (int k = 0; k < 3; k++) check_reset(k);

        // Two-beat frame, then truncation cases.
        send_beat(0, 8'd3, 8'd5, 1'b0, ended);
        send_beat(0, 8'd7, 8'd9, 1'b1, ended);
        check_frame("two_beat", 78, 2, 0);
        drain(0);
        send_beat(0, 8'd200, 8'd3, 1'b1, ended);
        check_frame("trunc_600", 88, 1, 0);
        drain(1);
        send_beat(0, 8'd255, 8'd255, 1'b1, ended);
        check_frame("trunc_ff", 1, 1, 0);
        drain(0);

        // Accumulator wrap on the 10-bit instance.
        for (int i = 0; i < 5; i++) send_beat(1, 8'd15, 8'd17, (i == 4), ended);
        check_frame("overflow", 251, 5, 1);
        drain(2);

        // Forced end after four beats; a further beat must stall while the result is held.
        for (int i = 0; i < 4; i++) send_beat(2, 8'd1, 8'd2, 1'b0, ended);
        check_frame("forced", 8, 4, 0);
        sel = 2;
        in_a = 8'd9;
        in_b = 8'd9;
        in_last = 1'b1;
        in_valid[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_in_ready", 32'(o_ready), 0);
            check_eq("stall_count", 32'(o_cnt), 4);
            @(posedge clk);
            #1;
        end
        in_valid[2] = 1'b0;
        in_last = 1'b0;
        drain(0);

        // Backpressure, then confirm the next frame starts from zero.
        send_beat(0, 8'd4, 8'd4, 1'b1, ended);
        drain(3);
        send_beat(0, 8'd1, 8'd1, 1'b1, ended);
        check_frame("after_fire", 1, 1, 0);
        drain(0);

        // Reset mid-frame discards the partial sum; reset in HOLD clears the result.
        send_beat(0, 8'd5, 8'd5, 1'b0, ended);
        send_beat(0, 8'd6, 8'd6, 1'b0, ended);
        do_reset();
        check_reset(0);
        send_beat(0, 8'd2, 8'd2, 1'b1, ended);
        check_frame("post_reset", 4, 1, 0);
        drain(0);
        send_beat(1, 8'd10, 8'd10, 1'b1, ended);
        do_reset();
        check_reset(1);

        // Randomized frames with idle gaps and random backpressure.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 60; n++) begin
                send_beat(k, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), ended);
                if (ended) begin
                    drain(int'($urandom_range(0, 2)));
                end else if ($urandom_range(0, 2) == 0) begin
                    in_a = 8'($urandom);
                    in_b = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul8_mac_stage.md
Name: mul8_mac_stage

Overview:
- Sequential multiply-accumulate stage placed directly downstream of the team's combinational 8x8 low-product multiplier (mul8_lo).
- Takes a stream of 8-bit operand pairs under valid/ready and forms each product modulo 256, which is the same function the combinational block produces.
- Accumulates the products into a wider register until a last-beat marker or a beat-count limit, then presents the sum, beat count and a sticky overflow flag under a valid/ready handshake.
- Serves as the sequential benchmark companion to the combinational multiplier.

Parameters:
ACC_W, 16, accumulator and out_sum width in bits; legal range 9..32
CNT_W, 8, beat-counter width in bits
MAX_BEATS, 255, forced frame end after this many beats; legal range 1..2^CNT_W-1

Ports:
clk  input  1  clock; all logic is on the rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  stage can accept an operand pair
in_a  input  8  multiplicand
in_b  input  8  multiplier
in_last  input  1  final beat of the frame
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_sum  output  ACC_W  accumulated sum of products, modulo 2^ACC_W
out_count  output  CNT_W  number of beats in the frame
out_ovf  output  1  set if the accumulator wrapped during the frame

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n low at a rising edge, including mid-frame or while HOLD):
  - state goes to IDLE; acc, cnt and ovf are cleared to 0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - Any partial frame is discarded.
- Product: prod = (in_a*in_b) mod 256, an 8-bit unsigned value computed combinationally by mul8_lo. It is zero-extended to ACC_W before the add.
- States:
  - IDLE: waiting for the first beat of a frame.
  - ACC: frame in progress.
  - HOLD: result presented on the output.
- in_ready = 1 in IDLE and ACC; in_ready = 0 in HOLD.
- A beat is accepted when in_valid && in_ready at a rising edge. On acceptance:
  - acc <= acc + prod, modulo 2^ACC_W.
  - ovf <= ovf | carry-out of that add.
  - cnt <= cnt + 1.
- End of frame: if the accepted beat has in_last=1, or cnt+1 == MAX_BEATS:
  - go to HOLD.
  - register out_sum, out_count and out_ovf, including the current beat.
  - out_valid=1 in the next cycle.
  - Latency is therefore 1 cycle from accepting the last beat to out_valid.
- Without end of frame: IDLE->ACC on the first beat; stay in ACC otherwise. No beat means no change.
- HOLD:
  - out_valid=1; out_sum, out_count and out_ovf are held stable until out_valid && out_ready.
  - On that handshake: next state IDLE; acc, cnt and ovf cleared; out_valid=0 next cycle.
  - The output fire and a new input can never share a cycle, because in_ready=0 in HOLD. The earliest new-frame beat is one cycle after the fire.
- Outputs are registered. in_ready is a function of state only and has no combinational path from out_ready.
- Frame with a single beat and in_last=1: out_count=1.
- in_a and in_b are ignored when no beat is accepted. No X is allowed to propagate into acc.

Decomposition:
- Package mul8_mac_pkg holds:
  - the state enum {IDLE, ACC, HOLD};
  - the constant PROD_W=8;
  - a helper function that zero-extends the product to ACC_W.
- One sub-module, mul8_lo: purely combinational, 8x8 to an 8-bit low product, instantiated once.
- The FSM and accumulator live in the top module.

Test Plan:
- Two-beat frame: beats (3,5) then (7,9) with last -> out_sum=78, out_count=2, out_ovf=0, out_valid 1 cycle after the second beat.
- Truncation: single beat (200,3) with last -> out_sum=88 (600 mod 256), out_count=1; (255,255) with last -> out_sum=1.
- Overflow with ACC_W=10: five beats of (15,17), i.e. prod=255, last on the fifth -> out_sum=251 (1275-1024), out_ovf=1, out_count=5.
- Forced end with MAX_BEATS=4: four beats of (1,2) and in_last never set -> out_valid after the fourth beat, out_sum=8, out_count=4; the fifth beat is stalled (in_ready=0).
- Backpressure: hold out_ready=0 for 3 cycles in HOLD -> outputs stable and in_ready=0 throughout; out_ready=1 -> fire, then IDLE; next frame starts with acc=0.
- Reset mid-frame: two beats accepted, rst_n=0 for 1 cycle, then beat (2,2) with last -> out_sum=4, out_count=1, out_ovf=0.
